// File: rtl/mem_arbiter_if.sv
// Request/response and byte-port signals shared between mem_arbiter and its clients.
// The slave modport is the arbiter's view; master is the clients' and RAM's view.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_done;
   logic [31:0]       ic_data;

   logic              ls_req;
   logic              ls_we;
   logic [1:0]        ls_size;
   logic [ADDR_W-1:0] ls_addr;
   logic [31:0]       ls_wdata;
   logic              ls_done;
   logic [31:0]       ls_rdata;

   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;
   logic              io_buffer_full;

   modport slave (
      input  ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
             io_buffer_full,
      output ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );

   modport master (
      output ic_req, ic_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
             io_buffer_full,
      input  ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the load/store buffer.
// Each access runs as consecutive byte cycles; read bytes arrive one cycle after their address.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter bit          IC_FAIR = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         flush,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StWaitIo} state_e;

   state_e            state_q, state_d;
   logic              own_ls_q, own_ls_d;
   logic              io_q, io_d;
   logic              fair_q, fair_d;
   logic [2:0]        n_q, n_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic              ic_done_q, ic_done_d;
   logic              ls_done_q, ls_done_d;
   logic [31:0]       ic_data_q, ic_data_d;
   logic [31:0]       ls_rdata_q, ls_rdata_d;

   logic       ic_cand, ls_cand, pick_ls, ls_is_io;
   logic [1:0] byte_idx;

   // A requester whose done is showing still holds req this cycle; don't re-grant it.
   assign ic_cand  = bus.ic_req & ~ic_done_q;
   assign ls_cand  = bus.ls_req & ~ls_done_q;
   assign pick_ls  = ls_cand & (~ic_cand | ~(IC_FAIR & fair_q));
   assign ls_is_io = bus.ls_we & (bus.ls_addr[17:16] == 2'b11);
   assign byte_idx = cnt_q[1:0] - 2'd1;

   always_comb begin
      state_d    = state_q;
      own_ls_d   = own_ls_q;
      io_d       = io_q;
      fair_d     = fair_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      ic_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      ic_data_d  = ic_data_q;
      ls_rdata_d = ls_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (!flush && (ic_cand || ls_cand)) begin
               cnt_d  = 3'd0;
               rbuf_d = 32'h0;
               if (pick_ls) begin
                  own_ls_d   = 1'b1;
                  fair_d     = 1'b1;
                  mem_a_d    = bus.ls_addr;
                  wdata_d    = bus.ls_wdata;
                  mem_dout_d = bus.ls_wdata[7:0];
                  io_d       = ls_is_io;
                  case (bus.ls_size)
                     2'd0:    n_d = 3'd1;
                     2'd1:    n_d = 3'd2;
                     default: n_d = 3'd4;
                  endcase
                  if (!bus.ls_we) begin
                     state_d = StRd;
                  end else if (ls_is_io && bus.io_buffer_full) begin
                     state_d = StWaitIo;
                  end else begin
                     state_d = StWr;
                  end
               end else begin
                  own_ls_d = 1'b0;
                  fair_d   = 1'b0;
                  mem_a_d  = bus.ic_addr;
                  n_d      = 3'd4;
                  io_d     = 1'b0;
                  state_d  = StRd;
               end
            end
         end

         StRd: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               // cnt_q counts addresses issued; the byte for address cnt_q-1 is on mem_din now.
               if (cnt_q != 3'd0) begin
                  case (byte_idx)
                     2'd0:    rbuf_d[7:0]   = bus.mem_din;
                     2'd1:    rbuf_d[15:8]  = bus.mem_din;
                     2'd2:    rbuf_d[23:16] = bus.mem_din;
                     default: rbuf_d[31:24] = bus.mem_din;
                  endcase
               end
               if (cnt_q == n_q) begin
                  state_d = StIdle;
                  if (own_ls_q) begin
                     ls_done_d  = 1'b1;
                     ls_rdata_d = rbuf_d;
                  end else begin
                     ic_done_d = 1'b1;
                     ic_data_d = rbuf_d;
                  end
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  mem_a_d = mem_a_q + ADDR_W'(1);
               end
            end
         end

         StWr: begin
            if (io_q && bus.io_buffer_full) begin
               state_d = StWaitIo;
            end else if (cnt_q == n_q - 3'd1) begin
               state_d   = StIdle;
               ls_done_d = 1'b1;
            end else begin
               cnt_d      = cnt_q + 3'd1;
               mem_a_d    = mem_a_q + ADDR_W'(1);
               wdata_d    = {8'h00, wdata_q[31:8]};
               mem_dout_d = wdata_q[15:8];
            end
         end

         StWaitIo: begin
            if (!bus.io_buffer_full) state_d = StWr;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         own_ls_q   <= 1'b0;
         io_q       <= 1'b0;
         fair_q     <= 1'b0;
         n_q        <= 3'd0;
         cnt_q      <= 3'd0;
         mem_a_q    <= '0;
         mem_dout_q <= 8'h0;
         wdata_q    <= 32'h0;
         rbuf_q     <= 32'h0;
         ic_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         ic_data_q  <= 32'h0;
         ls_rdata_q <= 32'h0;
      end else if (rdy) begin
         state_q    <= state_d;
         own_ls_q   <= own_ls_d;
         io_q       <= io_d;
         fair_q     <= fair_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         wdata_q    <= wdata_d;
         rbuf_q     <= rbuf_d;
         ic_done_q  <= ic_done_d;
         ls_done_q  <= ls_done_d;
         ic_data_q  <= ic_data_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   // An IO byte is only written while the UART has room.
   assign bus.mem_wr   = rdy & (state_q == StWr) & ~(io_q & bus.io_buffer_full);
   assign bus.mem_a    = mem_a_q;
   assign bus.mem_dout = mem_dout_q;
   assign bus.ic_done  = ic_done_q;
   assign bus.ic_data  = ic_data_q;
   assign bus.ls_done  = ls_done_q;
   assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected writes/done events into a queue,
// a negedge monitor pops and compares them as the arbiter produces them.
module tb_mem_arbiter;
   localparam int unsigned AW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   logic flush = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   mem_arbiter_if #(.ADDR_W(AW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .IC_FAIR(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM with a one-cycle registered read; paused together with the core when rdy is low.
   logic [7:0] ram [logic [31:0]];
   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction
   always @(posedge clk) begin
      if (rdy) bus.mem_din <= ram_rd(bus.mem_a);
      if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
   end

   typedef struct {
      int          kind;   // 0 = RAM write, 1 = ic_done, 2 = ls_done
      logic [31:0] addr;
      logic [31:0] data;
   } evt_t;
   evt_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
      evt_t e;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic check_evt(input int kind, input logic [31:0] a, input logic [31:0] d);
      evt_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_event @cycle %0d: kind %0d addr %h data %h, none expected",
                  cyc, kind, a, d);
         return;
      end
      e = exp_q.pop_front();
      chk("evt_kind", kind, e.kind);
      if (e.kind == 0) chk("wr_addr", a, e.addr);
      chk("evt_data", d, e.data);
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (bus.mem_wr)  check_evt(0, bus.mem_a, {24'h0, bus.mem_dout});
         if (bus.ic_done) check_evt(1, 32'h0, bus.ic_data);
         if (bus.ls_done) check_evt(2, 32'h0, bus.ls_rdata);
      end
   end

   task automatic goto_pos(input int y);
      while (cyc < y) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto_neg(input int x);
      while (cyc < x || clk) @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_evt(input string nm, input bit ls, input int budget, input int exp_cyc);
      int n;
      n = 0;
      if (clk) @(negedge clk);
      while (!(ls ? bus.ls_done : bus.ic_done) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: no done within %0d cycles, expected at cycle %0d", nm, budget, exp_cyc);
      end else begin
         chk(nm, cyc, exp_cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_a"}, bus.mem_a, 32'h0);
      chk({tag, "_mem_dout"}, {24'h0, bus.mem_dout}, 32'h0);
      chk({tag, "_mem_wr"}, {31'h0, bus.mem_wr}, 32'h0);
      chk({tag, "_ic_done"}, {31'h0, bus.ic_done}, 32'h0);
      chk({tag, "_ls_done"}, {31'h0, bus.ls_done}, 32'h0);
      chk({tag, "_ic_data"}, bus.ic_data, 32'h0);
      chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t;
      bus.ic_req = 1'b0;  bus.ic_addr = '0;
      bus.ls_req = 1'b0;  bus.ls_we = 1'b0;  bus.ls_size = 2'd0;
      bus.ls_addr = '0;   bus.ls_wdata = 32'h0;
      bus.io_buffer_full = 1'b0;
      bus.mem_din = 8'h0;
      ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
      ram[32'h104] = 8'h93; ram[32'h105] = 8'h00; ram[32'h106] = 8'h10; ram[32'h107] = 8'h00;
      ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      tick();
      rst = 1'b0;
      mon_en = 1'b1;
      tick();
      tick();

      // Fetch of 0x100: bytes on T+1..T+4, done at T+6.
      t = cyc;
      push(1, 32'h0, 32'h00000513);
      bus.ic_req = 1'b1;  bus.ic_addr = 32'h100;
      for (int i = 0; i < 4; i++) begin
         goto_neg(t + 1 + i);
         chk("fetch_addr", bus.mem_a, 32'h100 + i);
      end
      wait_evt("fetch_done_cycle", 1'b0, 20, t + 6);
      bus.ic_req = 1'b0;

      // Both request: LS first, then IC in the IDLE cycle of ls_done, then LS again.
      tick();
      t = cyc;
      push(2, 32'h0, 32'h44332211);
      push(1, 32'h0, 32'h00100093);
      push(2, 32'h0, 32'h44332211);
      bus.ic_req = 1'b1;  bus.ic_addr = 32'h104;
      bus.ls_req = 1'b1;  bus.ls_we = 1'b0;  bus.ls_size = 2'd2;  bus.ls_addr = 32'h200;
      goto_neg(t + 1);
      chk("fair_ls_first", bus.mem_a, 32'h200);
      wait_evt("fair_ls_done", 1'b1, 20, t + 6);
      goto_neg(t + 7);
      chk("fair_ic_next", bus.mem_a, 32'h104);
      wait_evt("fair_ic_done", 1'b0, 20, t + 12);
      bus.ic_req = 1'b0;
      wait_evt("fair_ls2_done", 1'b1, 20, t + 18);
      bus.ls_req = 1'b0;

      // Store half 0xBEEF to 0x1001.
      tick();
      t = cyc;
      push(0, 32'h1001, 32'hEF);
      push(0, 32'h1002, 32'hBE);
      push(2, 32'h0, 32'h44332211);
      bus.ls_req = 1'b1;  bus.ls_we = 1'b1;  bus.ls_size = 2'd1;
      bus.ls_addr = 32'h1001;  bus.ls_wdata = 32'h1234BEEF;
      wait_evt("store_half_done", 1'b1, 20, t + 3);
      bus.ls_req = 1'b0;

      // IO store with the UART full for five cycles.
      tick();
      t = cyc;
      bus.io_buffer_full = 1'b1;
      push(0, 32'h30000, 32'h41);
      push(2, 32'h0, 32'h44332211);
      bus.ls_req = 1'b1;  bus.ls_we = 1'b1;  bus.ls_size = 2'd0;
      bus.ls_addr = 32'h30000;  bus.ls_wdata = 32'h41;
      goto_pos(t + 5);
      bus.io_buffer_full = 1'b0;
      wait_evt("io_store_done", 1'b1, 20, t + 7);
      bus.ls_req = 1'b0;

      // Flush on the 3rd fetch byte, then a word store that a flush must not abort.
      tick();
      t = cyc;
      bus.ic_req = 1'b1;  bus.ic_addr = 32'h100;
      goto_pos(t + 3);
      flush = 1'b1;
      goto_neg(t + 3);
      chk("flush_third_addr", bus.mem_a, 32'h102);
      goto_pos(t + 4);
      flush = 1'b0;
      bus.ic_req = 1'b0;
      push(0, 32'h2000, 32'h0D);
      push(0, 32'h2001, 32'hF0);
      push(0, 32'h2002, 32'hFE);
      push(0, 32'h2003, 32'hCA);
      push(2, 32'h0, 32'h44332211);
      bus.ls_req = 1'b1;  bus.ls_we = 1'b1;  bus.ls_size = 2'd2;
      bus.ls_addr = 32'h2000;  bus.ls_wdata = 32'hCAFEF00D;
      goto_neg(t + 5);
      chk("idle_after_flush", bus.mem_a, 32'h2000);
      chk("idle_after_flush_wr", {31'h0, bus.mem_wr}, 32'h1);
      goto_pos(t + 6);
      flush = 1'b1;
      goto_pos(t + 7);
      flush = 1'b0;
      wait_evt("flush_store_done", 1'b1, 20, t + 9);
      bus.ls_req = 1'b0;

      // Word load stalled by rdy for three cycles.
      tick();
      t = cyc;
      push(2, 32'h0, 32'hCAFEF00D);
      bus.ls_req = 1'b1;  bus.ls_we = 1'b0;  bus.ls_size = 2'd2;  bus.ls_addr = 32'h2000;
      goto_pos(t + 2);
      rdy = 1'b0;
      for (int i = 2; i < 5; i++) begin
         goto_neg(t + i);
         chk("stall_addr", bus.mem_a, 32'h2001);
         chk("stall_wr", {31'h0, bus.mem_wr}, 32'h0);
      end
      goto_pos(t + 5);
      rdy = 1'b1;
      wait_evt("stall_done", 1'b1, 30, t + 9);
      bus.ls_req = 1'b0;

      // Reset in the middle of a load, then a fetch must be granted straight away.
      tick();
      t = cyc;
      bus.ls_req = 1'b1;  bus.ls_we = 1'b0;  bus.ls_size = 2'd2;  bus.ls_addr = 32'h200;
      goto_pos(t + 3);
      rst = 1'b1;
      goto_pos(t + 4);
      rst = 1'b0;
      bus.ls_req = 1'b0;
      goto_neg(t + 4);
      check_zero("midreset");
      tick();
      t = cyc;
      push(1, 32'h0, 32'h00000513);
      bus.ic_req = 1'b1;  bus.ic_addr = 32'h100;
      goto_neg(t + 1);
      chk("post_reset_grant", bus.mem_a, 32'h100);
      wait_evt("post_reset_done", 1'b0, 20, t + 6);
      bus.ic_req = 1'b0;

      repeat (4) tick();
      chk("queue_empty", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM/IO port and shares it between two requesters: instruction fetch (fetch side of the instruction queue) and the store/load buffer.
- Sequences each 1/2/4-byte access as consecutive byte cycles.
- Captures read bytes one cycle after their address is driven, honours the UART-full backpressure and the global pause, and aborts speculative traffic on a ROB exception (flush).

Parameters:
- ADDR_W, 32, address width of requests and mem_a.
- IC_FAIR, 1, when 1 a pending fetch wins the next arbitration after any LSU grant; when 0 the LSU always wins.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  low = freeze all state, and mem_wr is forced to 0.
- flush  in  1  ROB exception pulse.
- ic_req  in  1  fetch request; level, held until ic_done.
- ic_addr  in  ADDR_W  fetch word address.
- ic_done  out  1  one-cycle pulse; ic_data valid.
- ic_data  out  32  fetched instruction, little-endian.
- ls_req  in  1  LSU request; level, held until ls_done.
- ls_we  in  1  1 = store.
- ls_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word).
- ls_addr  in  ADDR_W  LSU byte address.
- ls_wdata  in  32  store data; the low bytes are used.
- ls_done  out  1  one-cycle pulse.
- ls_rdata  out  32  load data, zero-extended; sign-extension is done by the LSU.
- mem_din  in  8  RAM/IO read byte.
- mem_dout  out  8  write byte.
- mem_a  out  ADDR_W  byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset values (rst high at a clk edge, overrides everything including mid-transfer):
  - state = IDLE.
  - mem_a, mem_dout, mem_wr, ic_done, ls_done, ic_data, ls_rdata all 0.
  - Fairness flag = 0.
- rdy low: every register holds its value and mem_wr = 0. The byte counter does not advance, so a read stalled by rdy re-issues the same address, and a write byte is repeated once rdy returns.
- States:
  - IDLE
  - RD: read; owner = IC or LS.
  - WR: write.
  - WAIT_IO: store to IO blocked.
- Arbitration (only in IDLE): candidates are ic_req and ls_req, excluding the requester whose done is high this cycle.
  - Both present: LS wins, unless IC_FAIR = 1 and the fairness flag = 1 (last grant was LS), in which case IC wins.
  - The fairness flag is set on an LS grant and cleared on an IC grant.
- Byte count N: IC = 4; LS = 1/2/4 per ls_size. Request fields are latched at grant.
- Read timing, grant decided in cycle T:
  - mem_a = addr+i during cycle T+1+i, for i = 0..N-1.
  - Byte i is captured from mem_din in cycle T+2+i into bits [8i+7:8i].
  - done is high in cycle T+N+2, with state IDLE in that same cycle.
  - Unused upper bytes of ls_rdata = 0.
  - A 4-byte read therefore occupies T+1..T+5, with done at T+6.
- Write timing:
  - mem_wr = 1, mem_a = addr+i, mem_dout = wdata[8i+7:8i] during cycle T+1+i.
  - ls_done is high in T+N+1.
  - mem_wr = 0 in every cycle not driving a write byte.
- IO store: ls_addr[17:16] == 2'b11 and ls_we = 1.
  - If io_buffer_full is high at grant, or at any write byte, enter WAIT_IO: mem_wr = 0, counter held.
  - Resume the same byte in the cycle after io_buffer_full is seen low.
- Flush:
  - At the clk edge where flush = 1, an IC transfer or LS load in progress is abandoned: state becomes IDLE, no done pulse, mem_wr = 0.
  - A store in progress (WR/WAIT_IO) is committed and completes normally, with ls_done issued.
  - Arbitration is suppressed in the flush cycle.
- Wrap-around: mem_a increments modulo 2^ADDR_W. There is no alignment requirement and no checking.
- done and data outputs are registered. ic_data and ls_rdata hold their last value until the next capture.

Test Plan:
- Fetch ic_addr=0x100, RAM bytes 13,05,00,00:
  - mem_a = 0x100..0x103 on cycles T+1..T+4.
  - ic_done at T+6, ic_data = 0x00000513.
- Simultaneous ic_req and ls_req (load word 0x200), IC_FAIR = 1:
  - LS served first.
  - IC is granted in the IDLE cycle right after ls_done, even though ls_req re-asserts.
- Store half 0xBEEF to 0x1001:
  - mem_wr = 1, (0x1001, 0xEF) then (0x1002, 0xBE).
  - ls_done at T+3.
  - mem_wr = 0 otherwise.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 5 cycles:
  - mem_wr stays 0 for those cycles.
  - Single write of 0x41 after full drops, then ls_done.
- flush during the 3rd byte of a fetch, and separately during a word store:
  - Fetch: no ic_done, IDLE next cycle.
  - Store: all 4 bytes are written and ls_done fires.
- rdy low for 3 cycles mid-load, then rst mid-load:
  - Load: mem_a frozen, mem_wr = 0, captured bytes correct, done delayed by 3 cycles.
  - rst: all outputs 0 and IDLE after the reset edge.
